// File: rtl/alu_result_stage_if.sv
// ALU result stage bus: ALU capture side, writeback side and NZCV status.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready on capture, wb_valid/wb_ready on writeback.
interface alu_result_stage_if;
  // capture side, driven by the ALU and issue logic
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic        set_flags;
  logic [31:0] alu_result;
  logic        alu_n;
  logic        alu_v;
  logic        alu_c;
  logic        alu_z;
  logic        flag_clr;
  // writeback side
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [3:0]  wb_rd;
  logic        wb_we;
  // architectural status
  logic        flag_n;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;

  modport master (
    output in_valid, opcode, rd, set_flags, alu_result,
    output alu_n, alu_v, alu_c, alu_z, flag_clr, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_rd, wb_we,
    input  flag_n, flag_z, flag_c, flag_v
  );

  modport slave (
    input  in_valid, opcode, rd, set_flags, alu_result,
    input  alu_n, alu_v, alu_c, alu_z, flag_clr, wb_ready,
    output in_ready, wb_valid, wb_data, wb_rd, wb_we,
    output flag_n, flag_z, flag_c, flag_v
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers ALU results toward writeback and keeps NZCV (build option ALU_RESULT_SKID_EN).
// Latency: 1 cycle from accept to wb_valid; flags update on the accept edge.
// Backpressure: skid build has a DEPTH-entry FIFO with registered in_ready; default build is one entry with in_ready = !wb_valid || wb_ready.
module alu_result_stage #(
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  alu_result_stage_if.slave bus
);

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  rd;
    logic        we;
  } wb_ent_t;

  logic    op_we;
  wb_ent_t in_ent;
  logic    in_rdy;
  logic    accept;
  logic    deliver;
  logic    head_vld;
  wb_ent_t head_ent;
  logic [3:0] nzcv_q;
  logic [3:0] nzcv_d;

  // Decode which opcodes actually write the register file; NOP, COMP and undefined codes ride along with we=0.
  always_comb begin
    op_we = 1'b0;
    case (bus.opcode)
      4'b0001, 4'b0010, 4'b0101, 4'b0110,
      4'b0111, 4'b1000, 4'b1001, 4'b1011: op_we = 1'b1;
      default:                            op_we = 1'b0;
    endcase
  end

  assign in_ent  = {bus.alu_result, bus.rd, op_we};
  assign accept  = bus.in_valid && in_rdy;
  assign deliver = head_vld && bus.wb_ready;

`ifdef ALU_RESULT_SKID_EN
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  wb_ent_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             in_ready_q;
  wb_ent_t          last_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Occupancy after this edge; in_ready is low when full so accept-on-full never occurs here.
  always_comb begin
    count_d = count_q;
    case ({accept, deliver})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage; contents are only observed when occupied, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= in_ent;
    end
  end

  // Pointers, occupancy, registered in_ready, and the last delivered entry for the idle wb_* hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      last_q     <= '0;
    end else begin
      if (accept) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (deliver) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        last_q   <= mem[rd_ptr_q];
      end
      count_q    <= count_d;
      in_ready_q <= (count_d < CNT_FULL);
    end
  end

  assign in_rdy   = in_ready_q;
  assign head_vld = (count_q != '0);
  assign head_ent = head_vld ? mem[rd_ptr_q] : last_q;
`else
  logic    vld_q;
  wb_ent_t ent_q;

  // Single holding register; a new accept may replace the head in the same cycle it is delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      ent_q <= '0;
    end else if (accept) begin
      vld_q <= 1'b1;
      ent_q <= in_ent;
    end else if (deliver) begin
      vld_q <= 1'b0;
    end
  end

  assign in_rdy   = !vld_q || bus.wb_ready;
  assign head_vld = vld_q;
  assign head_ent = ent_q;
`endif

  // Next NZCV: clear first, then the accepted flag-setting op overwrites the fields it owns.
  always_comb begin
    nzcv_d = nzcv_q;
    if (bus.flag_clr) begin
      nzcv_d = 4'b0000;
    end
    if (accept && bus.set_flags) begin
      case (bus.opcode)
        4'b0001, 4'b0010: begin
          nzcv_d[3] = bus.alu_n;
          nzcv_d[2] = (bus.alu_result == 32'd0);
          nzcv_d[1] = bus.alu_c;
          nzcv_d[0] = bus.alu_v;
        end
        4'b0011: nzcv_d[2] = bus.alu_z;
        default: begin
        end
      endcase
    end
  end

  // Architectural status register, independent of writeback back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzcv_q <= 4'b0000;
    end else begin
      nzcv_q <= nzcv_d;
    end
  end

  assign bus.in_ready = in_rdy;
  assign bus.wb_valid = head_vld;
  assign bus.wb_data  = head_ent.data;
  assign bus.wb_rd    = head_ent.rd;
  assign bus.wb_we    = head_ent.we;
  assign bus.flag_n   = nzcv_q[3];
  assign bus.flag_z   = nzcv_q[2];
  assign bus.flag_c   = nzcv_q[1];
  assign bus.flag_v   = nzcv_q[0];

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random traffic against a queue model.
// Latency: checks sampled one time unit after each falling edge.
// Backpressure: wb_ready driven randomly and held low in the stall scenarios.
module tb_alu_result_stage;

`ifdef ALU_RESULT_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  rd;
    logic        we;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  alu_result_stage_if bus();

  alu_result_stage #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t m_q[$];
  ent_t m_last;
  logic [3:0] m_nzcv;
  logic dut_acc;

  function automatic logic we_of(input logic [3:0] op);
    return !(op == 4'd0 || op == 4'd3 || op == 4'd4 || op == 4'd10 || op >= 4'd12);
  endfunction

  function automatic logic exp_in_ready();
`ifdef ALU_RESULT_SKID_EN
    return m_q.size() < CAP;
`else
    return (m_q.size() == 0) || bus.wb_ready;
`endif
  endfunction

  function automatic ent_t exp_head();
    return (m_q.size() != 0) ? m_q[0] : m_last;
  endfunction

  function automatic logic [3:0] dut_nzcv();
    return {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
  endfunction

  task automatic set_op(input logic v, input logic [3:0] op, input logic [3:0] r, input logic sf,
                        input logic [31:0] res, input logic [3:0] nzcv_in, input logic clr);
    bus.in_valid   = v;
    bus.opcode     = op;
    bus.rd         = r;
    bus.set_flags  = sf;
    bus.alu_result = res;
    {bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} = nzcv_in;
    bus.flag_clr   = clr;
  endtask

  // One clock: decide accept/deliver from the model, advance through the rising edge, update the model.
  task automatic clk_cycle();
    logic acc, del, clr, sf;
    logic [3:0] op;
    logic [31:0] res;
    ent_t e;
    #1;
    acc = bus.in_valid && exp_in_ready();
    del = (m_q.size() != 0) && bus.wb_ready;
    dut_acc = bus.in_valid && bus.in_ready;
    clr = bus.flag_clr;
    sf  = bus.set_flags;
    op  = bus.opcode;
    res = bus.alu_result;
    e   = '{data: res, rd: bus.rd, we: we_of(op)};
    if (clr) m_nzcv = 4'b0000;
    if (acc && sf) begin
      if (op == 4'd1 || op == 4'd2) m_nzcv = {bus.alu_n, res == 32'd0, bus.alu_c, bus.alu_v};
      else if (op == 4'd3) m_nzcv[2] = bus.alu_z;
    end
    @(posedge clk);
    if (del) m_last = m_q.pop_front();
    if (acc) m_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    set_op(1'b0, 4'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) clk_cycle();
  endtask

  task automatic test_reset();
    set_op(1'b0, 4'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    bus.wb_ready = 1'b0;
    #2 rst_n = 1'b0;
    m_q.delete();
    m_last = '0;
    m_nzcv = 4'b0000;
    @(negedge clk);
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got %b want 0", bus.wb_valid); end
    n_vec++; if ({bus.wb_data, bus.wb_rd, bus.wb_we} !== 37'd0) begin n_err++; $display("FAIL reset_wb_fields got %h/%h/%b want 0", bus.wb_data, bus.wb_rd, bus.wb_we); end
    n_vec++; if (dut_nzcv() !== 4'b0000) begin n_err++; $display("FAIL reset_nzcv got %b want 0000", dut_nzcv()); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_add_overflow();
    bus.wb_ready = 1'b1;
    set_op(1'b1, 4'd1, 4'd3, 1'b1, 32'h8000_0000, 4'b1001, 1'b0);
    clk_cycle();
    set_op(1'b0, 4'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    n_vec++; if (bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL add_wb_valid got %b want 1", bus.wb_valid); end
    n_vec++; if (bus.wb_data !== 32'h8000_0000) begin n_err++; $display("FAIL add_wb_data got %h want 80000000", bus.wb_data); end
    n_vec++; if (bus.wb_rd !== 4'd3 || bus.wb_we !== 1'b1) begin n_err++; $display("FAIL add_rd_we got %h/%b want 3/1", bus.wb_rd, bus.wb_we); end
    n_vec++; if (dut_nzcv() !== 4'b1001) begin n_err++; $display("FAIL add_nzcv got %b want 1001", dut_nzcv()); end
    drain();
  endtask

  task automatic test_sub_comp();
    bus.wb_ready = 1'b1;
    set_op(1'b1, 4'd2, 4'd1, 1'b1, 32'd0, 4'b0010, 1'b0);
    clk_cycle();
    n_vec++; if (dut_nzcv() !== 4'b0110) begin n_err++; $display("FAIL sub_nzcv got %b want 0110", dut_nzcv()); end
    // ALU N/C/V deliberately set: COMP must ignore them
    set_op(1'b1, 4'd3, 4'd2, 1'b1, 32'h1234, 4'b1011, 1'b0);
    clk_cycle();
    n_vec++; if (dut_nzcv() !== 4'b0010) begin n_err++; $display("FAIL comp_nzcv got %b want 0010", dut_nzcv()); end
    n_vec++; if (bus.wb_we !== 1'b0 || bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL comp_we got we=%b vld=%b want 0/1", bus.wb_we, bus.wb_valid); end
    drain();
  endtask

  task automatic test_and_nop();
    bus.wb_ready = 1'b1;
    set_op(1'b1, 4'd5, 4'd5, 1'b1, 32'd0, 4'b1111, 1'b0);
    clk_cycle();
    n_vec++; if (dut_nzcv() !== 4'b0010) begin n_err++; $display("FAIL and_nzcv got %b want 0010", dut_nzcv()); end
    n_vec++; if (bus.wb_rd !== 4'd5 || bus.wb_we !== 1'b1) begin n_err++; $display("FAIL and_rd_we got %h/%b want 5/1", bus.wb_rd, bus.wb_we); end
    set_op(1'b1, 4'd0, 4'd6, 1'b1, 32'hdead, 4'b1111, 1'b0);
    clk_cycle();
    set_op(1'b0, 4'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    n_vec++; if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 4'd6 || bus.wb_we !== 1'b0) begin n_err++; $display("FAIL nop_entry got vld=%b rd=%h we=%b want 1/6/0", bus.wb_valid, bus.wb_rd, bus.wb_we); end
    drain();
  endtask

  task automatic test_backpressure();
    int acc_n;
    drain();
    bus.wb_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 4; i++) begin
      set_op(1'b1, 4'd6, 4'(acc_n + 1), 1'b0, 32'hA1 + 32'(acc_n), 4'd0, 1'b0);
      clk_cycle();
      if (dut_acc) acc_n++;
    end
    set_op(1'b0, 4'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    n_vec++; if (acc_n !== CAP) begin n_err++; $display("FAIL bp_accepts got %0d want %0d", acc_n, CAP); end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
    bus.wb_ready = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      n_vec++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'hA1 + 32'(i)) begin n_err++; $display("FAIL bp_drain%0d got vld=%b data=%h want 1/%h", i, bus.wb_valid, bus.wb_data, 32'hA1 + 32'(i)); end
      clk_cycle();
    end
    n_vec++; if (bus.wb_valid !== 1'b0 || bus.wb_data !== 32'hA0 + 32'(CAP)) begin n_err++; $display("FAIL bp_empty_hold got vld=%b data=%h want 0/%h", bus.wb_valid, bus.wb_data, 32'hA0 + 32'(CAP)); end
  endtask

  task automatic test_flag_clr();
    bus.wb_ready = 1'b1;
    set_op(1'b1, 4'd1, 4'd1, 1'b1, 32'd0, 4'b1011, 1'b0);
    clk_cycle();
    n_vec++; if (dut_nzcv() !== 4'b1111) begin n_err++; $display("FAIL clr_setup got %b want 1111", dut_nzcv()); end
    set_op(1'b1, 4'd3, 4'd1, 1'b1, 32'h55, 4'b1111, 1'b1);
    clk_cycle();
    n_vec++; if (dut_nzcv() !== 4'b0100) begin n_err++; $display("FAIL clr_comp got %b want 0100", dut_nzcv()); end
    drain();
  endtask

  task automatic test_random();
    ent_t h;
    for (int i = 0; i < 400; i++) begin
      set_op($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
             4'($urandom_range(0, 15)), $urandom_range(0, 15) == 0);
      bus.wb_ready = $urandom_range(0, 3) != 0;
      clk_cycle();
      h = exp_head();
      n_vec++; if (bus.in_ready !== exp_in_ready()) begin n_err++; $display("FAIL rnd%0d in_ready got %b want %b", i, bus.in_ready, exp_in_ready()); end
      n_vec++; if (bus.wb_valid !== (m_q.size() != 0)) begin n_err++; $display("FAIL rnd%0d wb_valid got %b want %b", i, bus.wb_valid, m_q.size() != 0); end
      n_vec++; if (bus.wb_data !== h.data) begin n_err++; $display("FAIL rnd%0d wb_data got %h want %h", i, bus.wb_data, h.data); end
      n_vec++; if (bus.wb_rd !== h.rd || bus.wb_we !== h.we) begin n_err++; $display("FAIL rnd%0d rd_we got %h/%b want %h/%b", i, bus.wb_rd, bus.wb_we, h.rd, h.we); end
      n_vec++; if (dut_nzcv() !== m_nzcv) begin n_err++; $display("FAIL rnd%0d nzcv got %b want %b", i, dut_nzcv(), m_nzcv); end
    end
  endtask

  task automatic test_reset_midop();
    drain();
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_op(1'b1, 4'd1, 4'd9, 1'b1, 32'h100 + 32'(i), 4'b1011, 1'b0);
      clk_cycle();
    end
    set_op(1'b0, 4'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0);
    n_vec++; if (bus.wb_valid !== 1'b1 || dut_nzcv() !== 4'b1011) begin n_err++; $display("FAIL midrst_setup got vld=%b nzcv=%b want 1/1011", bus.wb_valid, dut_nzcv()); end
    #1 rst_n = 1'b0;
    #1;
    m_q.delete();
    m_last = '0;
    m_nzcv = 4'b0000;
    n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL midrst_wb_valid got %b want 0", bus.wb_valid); end
    n_vec++; if (dut_nzcv() !== 4'b0000) begin n_err++; $display("FAIL midrst_nzcv got %b want 0000", dut_nzcv()); end
    n_vec++; if (bus.wb_data !== 32'd0) begin n_err++; $display("FAIL midrst_wb_data got %h want 0", bus.wb_data); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_comp();
    test_and_nop();
    test_backpressure();
    test_flag_clr();
    test_random();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Pipeline stage directly downstream of the 32-bit combinational ALU. Captures each ALU result with its destination register, buffers it toward register writeback over a valid/ready handshake, and maintains the architectural NZCV status register from the ALU's per-operation flag outputs. It removes the ALU output cone from the writeback timing path and provides one-operation-per-cycle throughput.

## Interface
Parameters:
- `DEPTH`, 2: result buffer entries when the skid buffer is compiled in; ignored otherwise, where depth is 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: ALU output and sideband are valid this cycle.
- `in_ready` out 1: stage accepts this cycle.
- `opcode` in 4: opcode the ALU evaluated, same encoding as the ALU.
- `rd` in 4: destination register index.
- `set_flags` in 1: the operation may update NZCV.
- `alu_result` in 32: ALU `output1`.
- `alu_n`, `alu_v`, `alu_c`, `alu_z` in 1 each: ALU flag outputs.
- `flag_clr` in 1: synchronous clear of NZCV.
- `wb_valid` out 1: head entry valid.
- `wb_ready` in 1: writeback consumes the head entry.
- `wb_data` out 32: head result.
- `wb_rd` out 4: head destination.
- `wb_we` out 1: head entry writes the register file.
- `flag_n`, `flag_z`, `flag_c`, `flag_v` out 1 each: architectural NZCV.

## Operation
- An operation is accepted when `in_valid && in_ready`. An entry is delivered when `wb_valid && wb_ready`.
- Buffer order is FIFO, and the head entry drives `wb_*`.
- `wb_we` is 0 for NOP (0000), COMP (0011), and any undefined opcode (0100, 1010, 11xx). It is 1 for ADD, SUB, AND, OR, NOT, XOR, SLL, and MOV.
- NOP, COMP, and undefined opcodes are still enqueued, so ordering is preserved. Writeback ignores them through `wb_we=0`.
- Flag update happens on accept, and only when `set_flags=1`:
  - ADD (0001) and SUB (0010): N←`alu_n`, C←`alu_c`, V←`alu_v`, Z←(`alu_result`==0). Z is computed here; the ALU's Z is not used for these opcodes.
  - COMP (0011): Z←`alu_z`. N, C, and V are held.
  - All other opcodes: no flag change, even when `set_flags=1`.
- Flags are independent of buffer back-pressure and never wait on writeback.
- `flag_clr`: NZCV←0000 at the next edge.
  - If `flag_clr` coincides with a flag-updating accept, the clear applies first, then the update overwrites the fields it writes. Example: COMP with `flag_clr` gives N=C=V=0 and Z=`alu_z`.
- Reset values:
  - `in_ready`=1.
  - `wb_valid`=0, `wb_data`=0, `wb_rd`=0, `wb_we`=0.
  - NZCV=0000.
  - Buffer empty, pointers at 0.
- Reset asserted mid-operation discards all buffered entries immediately (asynchronous) and clears the flags. No partial delivery occurs.

## Timing
- Latency: an entry accepted at edge k is visible on `wb_*` with `wb_valid=1` after edge k when the buffer was empty.
- Flags are visible after the accept edge.
- Throughput is 1 accept per cycle while `wb_ready=1`.
- Full buffer: `in_ready`=0, and `in_valid` is held by upstream.
- Empty buffer: `wb_valid`=0, and `wb_data`/`wb_rd`/`wb_we` hold their last values.
- Accept and deliver in the same cycle on a full buffer: allowed only in the non-skid build (see Configuration). Occupancy is unchanged.
- Pointers wrap modulo `DEPTH`.

## Configuration
- `ALU_RESULT_SKID_EN` defined:
  - `DEPTH`-entry buffer.
  - `in_ready` is a register equal to (occupancy < `DEPTH`), with no combinational path from `wb_ready`.
  - Sustains 1 per cycle with one stall of slack.
- `ALU_RESULT_SKID_EN` undefined:
  - Single entry.
  - `in_ready` = !`wb_valid` || `wb_ready` (combinational), which still gives 1 per cycle.

## Test plan
- Reset, then ADD A=0x7FFFFFFF B=1 with `set_flags`=1 (`alu_result`=0x80000000, n=1, v=1, c=0) → next cycle `wb_data`=0x80000000, `wb_we`=1, NZCV=1001.
- SUB with result 0x00000000 and c=1, `set_flags`=1 → Z=1, C=1; then COMP with `alu_z`=0 → Z=0, N/C/V unchanged.
- AND with `set_flags`=1 and `rd`=5 → NZCV unchanged, `wb_rd`=5, `wb_we`=1; then NOP → `wb_we`=0, entry still delivered in order.
- Hold `wb_ready`=0 and stream 3 ops → skid build: `in_ready` falls after 2 accepts, then entries 1 and 2 drain in order after `wb_ready`=1; non-skid build: stalls after 1.
- `flag_clr` together with an accepted COMP (`alu_z`=1, prior NZCV=1111) → NZCV=0100.
- Assert `rst_n`=0 with 2 entries buffered → `wb_valid`=0 and NZCV=0000 immediately; `in_ready`=1 after release.
